// File: rtl/data_mem_bridge.sv
// Data-memory bridge: core step strobe, load/store req/ack sequencing,
// stall generation and per-transaction timeout with sticky error flag.
//
// Ports:
//   clk, clr          clock, async active-low reset
//   proc_read_en      core load request
//   proc_write_en     core store request (wins if both are set)
//   proc_addr         core address, low ADDR_W bits forwarded
//   proc_wdata        core store data
//   proc_rdata        load data back to the core
//   pulse_en          one-cycle step strobe, period PULSE_DIV
//   stall             holds the core while an access is outstanding
//   mem_req/mem_we    external request / write select
//   mem_addr          registered external address
//   mem_wdata         registered store data
//   mem_ack           single-cycle completion from memory
//   mem_rdata         read data, valid with mem_ack
//   timeout_err       sticky abort flag

module data_mem_bridge #(
  parameter int unsigned PULSE_DIV = 4,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              proc_read_en,
  input  logic              proc_write_en,
  input  logic [31:0]       proc_addr,
  input  logic [15:0]       proc_wdata,
  output logic [15:0]       proc_rdata,
  output logic              pulse_en,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [15:0]       mem_rdata,
  output logic              timeout_err
);

  localparam int unsigned PCW =
    (PULSE_DIV > 1) ? $clog2(PULSE_DIV) : 1;
  localparam int unsigned TCW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [PCW-1:0] P_LAST = PCW'(PULSE_DIV - 1);
  localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT - 1);
  localparam logic [15:0] RD_ABORT = 16'hDEAD;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [PCW-1:0]    pcnt_q, pcnt_d;
  logic              pulse_q, pulse_d;
  logic              done_q, done_d;
  logic [TCW-1:0]    wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic req_any;
  logic stall_w;
  logic launch;
  logic ack_hit;
  logic tmo_hit;
  logic commit;

  // Upper address bits are intentionally dropped.
  logic unused_addr_hi;
  assign unused_addr_hi = ^proc_addr[31:ADDR_W];

  assign req_any = proc_read_en | proc_write_en;
  assign stall_w = req_any & ~done_q;
  assign launch  = (state_q == IDLE) & stall_w;
  assign ack_hit = (state_q == ACCESS) & mem_ack;
  // Ack in the last wait cycle takes priority over the abort.
  assign tmo_hit = (state_q == ACCESS) & ~mem_ack
                 & (wcnt_q == T_LAST);
  assign commit  = pulse_q & ~stall_w;

  // State register.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (launch) state_d = ACCESS;
      end
      ACCESS: begin
        if (ack_hit || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    mem_req     = (state_q == ACCESS);
    stall       = stall_w;
    pulse_en    = pulse_q;
    mem_we      = we_q;
    mem_addr    = addr_q;
    mem_wdata   = wdata_q;
    proc_rdata  = rdata_q;
    timeout_err = err_q;
  end

  // Datapath next-state.
  always_comb begin
    pcnt_d  = pcnt_q;
    pulse_d = 1'b0;
    done_d  = done_q;
    wcnt_d  = wcnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    // Free-running step strobe, never paused by stall.
    if (pcnt_q == P_LAST) begin
      pcnt_d  = '0;
      pulse_d = 1'b1;
    end else begin
      pcnt_d  = pcnt_q + PCW'(1);
    end

    // done masks the finished request until the core commits.
    if (ack_hit || tmo_hit) begin
      done_d = 1'b1;
    end else if (commit) begin
      done_d = 1'b0;
    end

    unique case (1'b1)
      launch: begin
        we_d    = proc_write_en;
        addr_d  = proc_addr[ADDR_W-1:0];
        wdata_d = proc_wdata;
        wcnt_d  = '0;
      end
      ack_hit: begin
        if (!we_q) rdata_d = mem_rdata;
      end
      tmo_hit: begin
        err_d = 1'b1;
        if (!we_q) rdata_d = RD_ABORT;
      end
      default: begin
        if (state_q == ACCESS) wcnt_d = wcnt_q + TCW'(1);
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pcnt_q  <= '0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
      wcnt_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
      wcnt_q  <= wcnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_bridge.sv
// Testbench for data_mem_bridge: vector table, hand sequences,
// randomized transactions against a transaction-level model.

module tb_data_mem_bridge;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        clr;
  logic        proc_read_en;
  logic        proc_write_en;
  logic [31:0] proc_addr;
  logic [15:0] proc_wdata;
  logic [15:0] proc_rdata;
  logic        pulse_en;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        timeout_err;

  always #5 clk = ~clk;

  data_mem_bridge dut (
    .clk          (clk),
    .clr          (clr),
    .proc_read_en (proc_read_en),
    .proc_write_en(proc_write_en),
    .proc_addr    (proc_addr),
    .proc_wdata   (proc_wdata),
    .proc_rdata   (proc_rdata),
    .pulse_en     (pulse_en),
    .stall        (stall),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .timeout_err  (timeout_err)
  );

  int total = 0;
  int bad   = 0;

  int   n_txn    = 0;
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (mem_req && !prev_req) n_txn++;
    prev_req = mem_req;
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [15:0] wdata;
    int          delay;
    logic [15:0] rdata;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    int          e_cyc;
    logic [15:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vt[7];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic run_txn(
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] a,
    input  logic [15:0] wd,
    input  int          dly,
    input  logic [15:0] rdv,
    input  bit          keep,
    output int          cyc,
    output logic        we,
    output logic [15:0] ad,
    output logic [15:0] wdo,
    output logic        st_req,
    output logic        st_end,
    output logic [15:0] rdo,
    output logic        er,
    output bit          ok
  );
    int cnt;
    cnt = 0;
    ok  = 1'b0;
    we  = 1'b0;
    ad  = '0;
    wdo = '0;
    proc_read_en  = rd;
    proc_write_en = wr;
    proc_addr     = a;
    proc_wdata    = wd;
    #1;
    st_req = stall;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'($urandom);
      if (mem_req) begin
        cnt++;
        if (cnt == 1) begin
          we  = mem_we;
          ad  = mem_addr;
          wdo = mem_wdata;
        end
        if (cnt == dly) begin
          mem_ack   = 1'b1;
          mem_rdata = rdv;
        end
      end else if (cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
    cyc    = cnt;
    st_end = stall;
    rdo    = proc_rdata;
    er     = timeout_err;
    if (!keep) begin
      proc_read_en  = 1'b0;
      proc_write_en = 1'b0;
    end
  endtask

  task automatic wait_commit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (pulse_en) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_case(input vec_t v, input string tag);
    int          cyc;
    logic        we, sr, se, er;
    logic [15:0] ad, wd, rd;
    bit          ok, okc;
    run_txn(v.rd, v.wr, v.addr, v.wdata, v.delay, v.rdata, 1'b0,
            cyc, we, ad, wd, sr, se, rd, er, ok);
    chk({tag, "_complete"}, 32'(ok), 32'd1);
    chk({tag, "_stall_req"}, 32'(sr), 32'd1);
    chk({tag, "_we"}, 32'(we), 32'(v.e_we));
    chk({tag, "_addr"}, 32'(ad), 32'(v.e_addr));
    chk({tag, "_wdata"}, 32'(wd), 32'(v.e_wdata));
    chk({tag, "_req_cycles"}, 32'(cyc), 32'(v.e_cyc));
    chk({tag, "_stall_end"}, 32'(se), 32'd0);
    chk({tag, "_rdata"}, 32'(rd), 32'(v.e_rdata));
    chk({tag, "_err"}, 32'(er), 32'(v.e_err));
    wait_commit(okc);
    chk({tag, "_commit"}, 32'(okc), 32'd1);
  endtask

  task automatic pulse_cadence(input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("%s_pulse%0d", tag, k), 32'(pulse_en),
          32'((k % 4) == 0));
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
    chk({tag, "_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rdata"}, 32'(proc_rdata), 32'd0);
    chk({tag, "_pulse"}, 32'(pulse_en), 32'd0);
    chk({tag, "_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int          cyc, viol, n0;
    logic        we, sr, se, er;
    logic [15:0] ad, wd, rd;
    bit          ok;
    logic [15:0] keep_rd;
    logic        keep_er;
    logic [15:0] rdata_m;
    logic        err_m;
    vec_t        v;

    vt[0] = '{1'b0, 1'b1, 32'h0000_1234, 16'hBEEF, 3, 16'h1111,
              1'b1, 16'h1234, 16'hBEEF, 3, 16'h0000, 1'b0};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0042, 16'h0000, 1, 16'h5A5A,
              1'b0, 16'h0042, 16'h0000, 1, 16'h5A5A, 1'b0};
    vt[2] = '{1'b1, 1'b1, 32'hABCD_0010, 16'h0F0F, 2, 16'h7777,
              1'b1, 16'h0010, 16'h0F0F, 2, 16'h5A5A, 1'b0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_FFFF, 16'h0000, 64, 16'hC3C3,
              1'b0, 16'hFFFF, 16'h0000, 64, 16'hC3C3, 1'b0};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0100, 16'h0000, 0, 16'h1234,
              1'b0, 16'h0100, 16'h0000, 64, 16'hDEAD, 1'b1};
    vt[5] = '{1'b0, 1'b1, 32'h0000_0200, 16'h5555, 5, 16'h9999,
              1'b1, 16'h0200, 16'h5555, 5, 16'hDEAD, 1'b1};
    vt[6] = '{1'b1, 1'b0, 32'h0000_0300, 16'h0000, 2, 16'h0001,
              1'b0, 16'h0300, 16'h0000, 2, 16'h0001, 1'b1};

    clr           = 1'b0;
    proc_read_en  = 1'b0;
    proc_write_en = 1'b0;
    proc_addr     = '0;
    proc_wdata    = '0;
    mem_ack       = 1'b0;
    mem_rdata     = '0;
    #1;
    chk_zero("por");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
    pulse_cadence("por");

    for (int i = 0; i < 7; i++) begin
      do_case(vt[i], $sformatf("vec%0d", i));
    end

    // Back-to-back loads across one commit.
    n0 = n_txn;
    run_txn(1'b1, 1'b0, 32'h0000_0042, 16'h0, 1, 16'h5A5A, 1'b1,
            cyc, we, ad, wd, sr, se, rd, er, ok);
    chk("b2b1_complete", 32'(ok), 32'd1);
    chk("b2b1_rdata", 32'(rd), 32'h5A5A);
    chk("b2b1_stall_end", 32'(se), 32'd0);
    viol = 0;
    ok   = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (pulse_en) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      if (mem_req) viol++;
    end
    chk("b2b_hold_pulse", 32'(ok), 32'd1);
    chk("b2b_hold_no_req", 32'(viol), 32'd0);
    run_txn(1'b1, 1'b0, 32'h0000_0044, 16'h0, 2, 16'hA5A5, 1'b0,
            cyc, we, ad, wd, sr, se, rd, er, ok);
    chk("b2b2_complete", 32'(ok), 32'd1);
    chk("b2b2_addr", 32'(ad), 32'h0044);
    chk("b2b2_cycles", 32'(cyc), 32'd2);
    chk("b2b2_rdata", 32'(rd), 32'hA5A5);
    wait_commit(ok);
    chk("b2b2_commit", 32'(ok), 32'd1);
    chk("b2b_count", 32'(n_txn - n0), 32'd2);

    // Stray ack in IDLE, then a dual-enable request.
    keep_rd   = proc_rdata;
    keep_er   = timeout_err;
    mem_ack   = 1'b1;
    mem_rdata = 16'hFFFF;
    @(negedge clk);
    chk("stray_req", 32'(mem_req), 32'd0);
    mem_ack = 1'b0;
    @(negedge clk);
    chk("stray_rdata", 32'(proc_rdata), 32'(keep_rd));
    chk("stray_err", 32'(timeout_err), 32'(keep_er));
    chk("stray_stall", 32'(stall), 32'd0);
    v = '{1'b1, 1'b1, 32'h0000_0777, 16'h1357, 1, 16'h2468,
          1'b1, 16'h0777, 16'h1357, 1, 16'hA5A5, 1'b1};
    n0 = n_txn;
    do_case(v, "both");
    chk("both_count", 32'(n_txn - n0), 32'd1);

    // Random transactions vs. transaction-level model.
    rdata_m = 16'hA5A5;
    err_m   = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int  sel;
      bit  acked;
      sel     = int'($urandom_range(0, 2));
      v.rd    = (sel != 1);
      v.wr    = (sel != 0);
      v.addr  = $urandom;
      v.wdata = 16'($urandom);
      v.rdata = 16'($urandom);
      if ($urandom_range(0, 4) == 0)
        v.delay = int'($urandom_range(60, 70));
      else
        v.delay = int'($urandom_range(1, 6));
      acked     = (v.delay >= 1) && (v.delay <= TMO);
      v.e_we    = v.wr;
      v.e_addr  = v.addr[15:0];
      v.e_wdata = v.wdata;
      v.e_cyc   = acked ? v.delay : TMO;
      if (!v.wr) rdata_m = acked ? v.rdata : 16'hDEAD;
      if (!acked) err_m = 1'b1;
      v.e_rdata = rdata_m;
      v.e_err   = err_m;
      do_case(v, $sformatf("rnd%0d", k));
    end

    // Asynchronous reset in the middle of a transaction.
    proc_read_en = 1'b1;
    proc_addr    = 32'h0000_3333;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_pre_req", 32'(ok), 32'd1);
    #2;
    clr          = 1'b0;
    proc_read_en = 1'b0;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    chk("mid_rst_hold_req", 32'(mem_req), 32'd0);
    clr = 1'b1;
    pulse_cadence("mid");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits directly downstream of the processor core and owns its data-memory port.
- Generates the core's step strobe (pulse_en) and turns each load/store the core decodes into a req/ack transaction on an external data-memory bus.
- Asserts stall until the transaction completes, then returns load data on proc_rdata.
- Bounds every transaction with a timeout so a dead memory cannot hang the core.

Parameters:
PULSE_DIV, 4, clk cycles per pulse_en strobe (legal values ≥ 2)
ADDR_W, 16, width of the external memory address
TIMEOUT, 64, max clk cycles mem_req may wait for mem_ack before abort

Ports:
clk  input  1  system clock (100MHz)
clr  input  1  reset, asynchronous, active-low
proc_read_en  input  1  core load request (memRead decode)
proc_write_en  input  1  core store request (memWrite decode)
proc_addr  input  32  core address (ALU result)
proc_wdata  input  16  core store data
proc_rdata  output  16  load data to the core writeback mux
pulse_en  output  1  one-cycle core step strobe
stall  output  1  holds the core while an access is outstanding
mem_req  output  1  external request, held until ack or abort
mem_we  output  1  1 = write, 0 = read; valid while mem_req
mem_addr  output  ADDR_W  proc_addr[ADDR_W-1:0], registered at request launch
mem_wdata  output  16  registered store data
mem_ack  input  1  single-cycle completion from memory
mem_rdata  input  16  read data, valid in the mem_ack cycle
timeout_err  output  1  sticky flag: a transaction was aborted

Behaviour:
- Reset (clr=0, asynchronous):
  - all state returns to reset values; FSM → IDLE.
  - pulse counter = 0, done = 0.
  - Outputs: pulse_en=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, proc_rdata=0, timeout_err=0.
  - A transaction in flight is dropped: mem_req falls immediately.
- Pulse generator:
  - Free-running counter over 0..PULSE_DIV-1.
  - pulse_en is registered; it is high for exactly one clk in the cycle after the counter reaches PULSE_DIV-1, giving period PULSE_DIV.
  - The counter never pauses for stall; the core simply ignores pulses while stall=1.
- stall = (proc_read_en | proc_write_en) & ~done.
  - Combinational, so the core never commits in the cycle a request appears.
- done flag:
  - set when a transaction completes or aborts.
  - cleared on any clk where pulse_en=1 and stall=0 (instruction commit), so the next instruction's request is seen as new.
- FSM states: IDLE, ACCESS.
  - IDLE → ACCESS when (proc_read_en|proc_write_en) & ~done. On that edge, register:
    - mem_req=1
    - mem_we=proc_write_en
    - mem_addr=proc_addr[ADDR_W-1:0]
    - mem_wdata=proc_wdata
    - wait counter=0
  - Minimum latency: request at cycle N, mem_req high at N+1; if mem_ack arrives at N+1, stall falls at N+2.
  - ACCESS, mem_ack=1 → IDLE:
    - mem_req=0, done=1.
    - if the access was a read: proc_rdata ← mem_rdata.
  - ACCESS, wait counter reaches TIMEOUT-1 without ack → IDLE:
    - mem_req=0, done=1, timeout_err=1.
    - if the access was a read: proc_rdata ← 16'hDEAD.
  - ack and timeout in the same cycle: ack wins, no error.
- proc_rdata holds its value until the next read completes; writes never change it.
- mem_ack in IDLE is ignored.
- proc_read_en and proc_write_en both high: treated as a write (mem_we=1); proc_rdata unchanged.
- Request inputs are sampled only at launch. Changes during ACCESS do not alter the in-flight transaction.
- timeout_err clears only on reset.
- Address bits proc_addr[31:ADDR_W] are discarded with no error.

Test Plan:
- Reset: hold clr=0 with mem_req active mid-transaction → all outputs 0 within the same cycle; after release, pulse_en first rises 4 clks later and then every 4 clks (PULSE_DIV=4).
- Store: write_en=1, addr=32'h0000_1234, wdata=16'hBEEF; memory acks 3 cycles after mem_req → mem_req high exactly 3 cycles with mem_we=1, mem_addr=16'h1234, mem_wdata=16'hBEEF; stall falls the cycle after ack; proc_rdata unchanged.
- Load: read_en=1, addr=0x0042, mem_rdata=16'h5A5A with ack → proc_rdata=16'h5A5A the cycle after ack; stall low; no second mem_req before the next pulse_en commit.
- Back-to-back loads from two instructions across one commit → exactly two mem_req transactions, with done cleared on the committing pulse_en.
- Timeout: read with mem_ack never asserted → mem_req high for exactly 64 cycles, then proc_rdata=16'hDEAD, timeout_err=1 (sticky), stall released.
- Both enables set, plus a spurious mem_ack in IDLE → single write transaction (mem_we=1); the stray ack causes no state change.
